// File: rtl/toggle_cover_detect.sv
`default_nettype none
// ============================================================================
// toggle_cover_detect : per-bit rise/fall history, one-cycle valid pulse on
// each bit's first full toggle, plus a running count of covered bits.
// Revision: 1.0
// ============================================================================
module toggle_cover_detect #(
    parameter int WIDTH = 28,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] valid,
    output logic [CNT_W-1:0] covered_cnt,
    output logic             all_covered
);

    logic [WIDTH-1:0] prev_q;
    logic             armed_q;
    logic [WIDTH-1:0] seen_rise_q;
    logic [WIDTH-1:0] seen_fall_q;
    logic [WIDTH-1:0] valid_q;
    logic [CNT_W-1:0] covered_cnt_q;
    logic             all_covered_q;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] seen_rise_d;
    logic [WIDTH-1:0] seen_fall_d;
    logic [WIDTH-1:0] w_new_done;
    logic [CNT_W-1:0] w_add;
    logic [CNT_W-1:0] covered_cnt_d;
    logic             all_covered_d;

    always_comb begin
        w_rise      = {WIDTH{armed_q & enable}} & ~prev_q & sig;
        w_fall      = {WIDTH{armed_q & enable}} & prev_q & ~sig;
        seen_rise_d = seen_rise_q | w_rise;
        seen_fall_d = seen_fall_q | w_fall;
        // Only bits crossing from not-done to done this edge produce a pulse.
        w_new_done  = (seen_rise_d & seen_fall_d) & ~(seen_rise_q & seen_fall_q);
        w_add       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_add = w_add + CNT_W'(w_new_done[i]);
        end
        covered_cnt_d = covered_cnt_q + w_add;
        all_covered_d = (covered_cnt_d == CNT_W'(WIDTH));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_q        <= '0;
            armed_q       <= 1'b0;
            seen_rise_q   <= '0;
            seen_fall_q   <= '0;
            valid_q       <= '0;
            covered_cnt_q <= '0;
            all_covered_q <= 1'b0;
        end else if (clear) begin
            // Reload prev so the next sample compares against a fresh baseline.
            prev_q        <= sig;
            armed_q       <= 1'b0;
            seen_rise_q   <= '0;
            seen_fall_q   <= '0;
            valid_q       <= '0;
            covered_cnt_q <= '0;
            all_covered_q <= 1'b0;
        end else begin
            prev_q        <= sig;
            armed_q       <= 1'b1;
            seen_rise_q   <= seen_rise_d;
            seen_fall_q   <= seen_fall_d;
            valid_q       <= w_new_done;
            covered_cnt_q <= covered_cnt_d;
            all_covered_q <= all_covered_d;
        end
    end

    assign valid       = valid_q;
    assign covered_cnt = covered_cnt_q;
    assign all_covered = all_covered_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_cover_detect.sv
`default_nettype none
// Testbench for toggle_cover_detect: directed vector table followed by
// randomized traffic checked against an edge-counting reference model.
module tb_toggle_cover_detect;

    localparam int WIDTH = 28;
    localparam int CNT_W = 5;
    localparam logic [WIDTH-1:0] ALL = 28'hFFFFFFF;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] valid;
    logic [CNT_W-1:0] covered_cnt;
    logic             all_covered;

    toggle_cover_detect #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .sig         (sig),
        .valid       (valid),
        .covered_cnt (covered_cnt),
        .all_covered (all_covered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             rst_n;
        logic             en;
        logic             clr;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] ev;
        int               ec;
        logic             ea;
    } vec_t;

    vec_t tbl[$];

    // Reference model: counts of edges seen per bit since the last epoch start.
    logic [WIDTH-1:0] m_prev;
    bit               m_armed;
    int               m_rises[WIDTH];
    int               m_falls[WIDTH];
    bit               m_cov[WIDTH];
    logic [WIDTH-1:0] m_valid;
    int               m_cnt;

    task automatic model_edge(input logic r, input logic e, input logic c, input logic [WIDTH-1:0] s);
        m_valid = '0;
        if (!r || c) begin
            for (int i = 0; i < WIDTH; i++) begin
                m_rises[i] = 0;
                m_falls[i] = 0;
                m_cov[i]   = 0;
            end
            m_armed = 0;
            m_prev  = r ? s : '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (m_armed && e && (m_prev[i] != s[i])) begin
                    if (s[i]) m_rises[i]++;
                    else      m_falls[i]++;
                end
                if (!m_cov[i] && m_rises[i] > 0 && m_falls[i] > 0) begin
                    m_cov[i]   = 1;
                    m_valid[i] = 1'b1;
                end
            end
            m_prev  = s;
            m_armed = 1;
        end
        m_cnt = 0;
        for (int i = 0; i < WIDTH; i++) m_cnt += int'(m_cov[i]);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic c, input logic [WIDTH-1:0] s);
        reset  = r;
        enable = e;
        clear  = c;
        sig    = s;
        @(posedge clock);
        #1;
        model_edge(r, e, c, s);
    endtask

    task automatic add(input logic r, input logic e, input logic c, input logic [WIDTH-1:0] s,
                       input logic [WIDTH-1:0] ev, input int ec, input logic ea);
        vec_t v;
        v.rst_n = r; v.en = e; v.clr = c; v.s = s; v.ev = ev; v.ec = ec; v.ea = ea;
        tbl.push_back(v);
    endtask

    initial begin
        logic [WIDTH-1:0] rs;
        logic             rr, re, rc;

        reset = 1'b0; enable = 1'b0; clear = 1'b0; sig = '0;

        // Bit 0 walk
        add(0,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h1,      28'h0, 0, 0);
        add(1,1,0, 28'h1,      28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h1, 1, 0);
        add(1,1,0, 28'h0,      28'h0, 1, 0);
        // Arming: first edge after release only captures the baseline
        add(0,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, ALL,        28'h0, 0, 0);
        add(1,1,0, ALL,        28'h0, 0, 0);
        // All bits together, then re-toggle
        add(0,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, ALL,        28'h0, 0, 0);
        add(1,1,0, 28'h0,      ALL,  28, 1);
        add(1,1,0, 28'h0,      28'h0, 28, 1);
        add(1,1,0, ALL,        28'h0, 28, 1);
        add(1,1,0, 28'h0,      28'h0, 28, 1);
        // Enable gating, no stale edge on re-enable
        add(0,0,0, 28'h0,      28'h0, 0, 0);
        add(1,0,0, 28'h0,      28'h0, 0, 0);
        add(1,0,0, 28'h8,      28'h0, 0, 0);
        add(1,0,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h0, 0, 0);
        add(1,0,0, 28'h8,      28'h0, 0, 0);
        add(1,1,0, 28'h8,      28'h0, 0, 0);
        // Clear collides with the fall of bit 2
        add(0,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h4,      28'h0, 0, 0);
        add(1,1,1, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h4,      28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h4, 1, 0);
        add(1,1,0, ALL,        28'h0, 1, 0);
        add(1,1,0, 28'h0,      28'hFFFFFFB, 28, 1);
        add(1,1,1, 28'h0,      28'h0, 0, 0);
        // Mid-operation reset after partial coverage
        add(1,1,0, 28'h0,      28'h0, 0, 0);
        add(1,1,0, 28'h30,     28'h0, 0, 0);
        add(1,1,0, 28'h0,      28'h30, 2, 0);
        add(0,1,0, 28'h0,      28'h0, 0, 0);

        foreach (tbl[k]) begin
            step(tbl[k].rst_n, tbl[k].en, tbl[k].clr, tbl[k].s);
            chk($sformatf("vec%0d valid", k), 32'(valid), 32'(tbl[k].ev));
            chk($sformatf("vec%0d cnt", k), 32'(covered_cnt), 32'(tbl[k].ec));
            chk($sformatf("vec%0d all", k), 32'(all_covered), 32'(tbl[k].ea));
        end

        // Randomized traffic with sparse bit flips so coverage builds gradually
        rs = '0;
        step(1'b0, 1'b1, 1'b0, rs);
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 149) != 0);
            rc = ($urandom_range(0, 59) == 0);
            re = ($urandom_range(0, 7) != 0);
            rs = rs ^ WIDTH'($urandom & $urandom & $urandom);
            step(rr, re, rc, rs);
            chk("rand valid", 32'(valid), 32'(m_valid));
            chk("rand cnt", 32'(covered_cnt), 32'(m_cnt));
            chk("rand all", 32'(all_covered), 32'(m_cnt == WIDTH));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/toggle_cover_detect.md
# toggle_cover_detect

Per-bit toggle-coverage detector that sits directly upstream of the toggle-coverage DPI reporters. It samples a WIDTH-bit design signal every cycle and detects rising and falling edges per bit. It keeps sticky rise-seen and fall-seen state per bit. When a bit completes its first full toggle (both edges observed), it emits a one-cycle pulse on that bit of `valid`, which the reporter consumes as its `valid` input. It also maintains a running count of covered bits.

## Interface
Parameters:
- `WIDTH`, default 28: number of monitored bits; must equal the downstream reporter's vector width.
- `CNT_W`, default 5: width of the covered-bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clock`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `enable`  in  1  edge detection enabled this cycle.
- `clear`  in  1  synchronous clear of all coverage state.
- `sig`  in  WIDTH  monitored signal.
- `valid`  out  WIDTH  registered one-cycle pulse per bit on first full toggle.
- `covered_cnt`  out  CNT_W  registered number of bits fully toggled.
- `all_covered`  out  1  registered; high when covered_cnt == WIDTH.

## Operation
- State:
  - `prev` (WIDTH): previous sample.
  - `armed` (1): `prev` is valid.
  - `seen_rise` and `seen_fall` (WIDTH each): sticky edge history.
  - Output registers for `valid`, `covered_cnt` and `all_covered`.
- Priority each edge: reset (low) > clear > normal update.
- Reset:
  - `prev`, `armed`, `seen_rise`, `seen_fall` all go to 0.
  - Outputs: `valid`=0, `covered_cnt`=0, `all_covered`=0.
- Clear:
  - `seen_rise`, `seen_fall`, `valid`, `covered_cnt` and `all_covered` go to 0.
  - `armed`=0; `prev` loads `sig`.
  - Any edge present in the same cycle is discarded.
- Normal update:
  - `prev` loads `sig` every cycle, regardless of `enable`.
  - `armed` goes to 1.
- Edge detect (combinational):
  - rise[i] = armed & enable & ~prev[i] & sig[i]
  - fall[i] = armed & enable & prev[i] & ~sig[i]
- Sticky update: seen_rise |= rise; seen_fall |= fall.
- Completion:
  - done = seen_rise & seen_fall, and done_next is computed from the updated sticky bits.
  - `valid` loads done_next & ~done, then returns to 0 the following cycle unless new bits complete.
- Count:
  - `covered_cnt` += popcount(done_next & ~done), using CNT_W-bit arithmetic.
  - It cannot exceed WIDTH, so no wrap or saturation logic is needed.
- `all_covered` loads (next covered_cnt == WIDTH) on the same edge.
- Once a bit is covered, further toggles of that bit never re-pulse `valid` until the next clear or reset.
- Rise and fall on the same bit in one cycle is impossible. A 0→1→0 bit completes on the fall edge.
- Any subset of bits, up to all WIDTH, may complete on the same edge. All of them pulse together and the count adds the full popcount.
- `enable`=0: no edges are recorded, but `prev` keeps tracking. Re-enabling therefore never produces a stale edge.

## Timing
- Edge sampled at clock edge k (sig_k vs sig_{k-1}) → `valid`, `covered_cnt` and `all_covered` are updated at edge k and visible in cycle k+1. Latency is 1 cycle from the sampling edge.
- First edge after reset release or clear only arms the block. The earliest detectable edge is at the second sampling edge.
- `valid` pulse width is exactly 1 cycle per bit per coverage epoch.
- There is no back-pressure. The downstream reporter consumes `valid` unconditionally each cycle.
- Reset asserted mid-operation takes effect at the next edge, and outputs read 0 in the following cycle.

## Test plan
- Bit 0 walk:
  - Stimulus: reset release with sig=0; drive sig=0x1 at edge 3, then sig=0x0 at edge 5.
  - Required response: `valid`=0x1 only in cycle 6; `covered_cnt`=1 from cycle 6; `valid`=0 at every other cycle.
- Arming:
  - Stimulus: sig=0xFFFFFFF on the first edge after reset release, then held.
  - Required response: `valid` stays 0 and `covered_cnt` stays 0.
- All bits together:
  - Stimulus: sig 0→0xFFFFFFF→0 on consecutive edges with `enable`=1.
  - Required response: `valid`=0xFFFFFFF for exactly one cycle; `covered_cnt`=28; `all_covered`=1.
- Re-toggle after coverage:
  - Stimulus: repeat the previous scenario's sequence.
  - Required response: `valid` stays 0; `covered_cnt` stays 28.
- Enable gating:
  - Stimulus: bit 3 toggles 0→1→0 with `enable`=0, then `enable`=1 with sig held.
  - Required response: no `valid` pulse; `covered_cnt`=0.
- Clear collision:
  - Stimulus: bit 2 has seen its rise; `clear`=1 on the same edge as its fall.
  - Required response: `valid`=0, `covered_cnt`=0, `seen_*` cleared; a fresh rise+fall is then needed to pulse `valid`[2].
